// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-style accumulator core.
// Instructions arrive over a valid/req fetch handshake. Each instruction takes
// one FETCH cycle (plus wait states) and one EXEC cycle. Adds run/stall
// control, a HLT instruction and a one-cycle output strobe.
module td4x_core #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [DW+3:0] imem_data,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          halted
);

    localparam int IW = DW + 4;

    // Jump targets are taken from the ALU result, so the PC cannot be wider than the data path.
    generate
        if (AW > DW) begin : g_bad_aw
            $error("td4x_core: AW (%0d) must not exceed DW (%0d)", AW, DW);
        end
    endgenerate

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_HLT    = 4'b1101;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_e;

    state_e        state;
    logic [AW-1:0] pc;
    logic [DW-1:0] a, b;
    logic          c;
    logic [IW-1:0] ir;
    logic          req_r;

    logic [3:0]    opcode;
    logic [DW-1:0] imm;
    logic [DW-1:0] src;
    logic [DW-1:0] res;
    logic          cout;

    assign opcode = ir[IW-1:DW];
    assign imm    = ir[DW-1:0];

    // ALU: pick the source operand by opcode and add the immediate.
    always_comb begin
        // NOTE: src gets a default before the case so no path leaves it unassigned and infers a latch.
        src = '0;
        case (opcode)
            OP_ADD_A, OP_MOV_BA:           src = a;
            OP_MOV_AB, OP_ADD_B, OP_OUT_B: src = b;
            OP_IN_A, OP_IN_B:              src = in_data;
            default:                       src = '0;
        endcase
        {cout, res} = {1'b0, src} + {1'b0, imm};
    end

    // Fetch gating: rst kills an outstanding request immediately, ahead of the reset edge.
    assign imem_req  = req_r & ~rst;
    assign imem_addr = pc;

    // Control FSM plus all architectural state; outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            a         <= '0;
            b         <= '0;
            c         <= 1'b0;
            ir        <= '0;
            req_r     <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                        req_r <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir    <= imem_data;
                        req_r <= 1'b0;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    pc <= pc + AW'(1);
                    case (opcode)
                        OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: begin
                            a <= res;
                            c <= cout;
                        end
                        OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: begin
                            b <= res;
                            c <= cout;
                        end
                        OP_OUT_B, OP_OUT_I: begin
                            out_data  <= res;
                            out_valid <= 1'b1;
                            c         <= cout;
                        end
                        OP_JNC: begin
                            // The branch tests the carry from before this instruction.
                            if (!c) pc <= res[AW-1:0];
                            c <= cout;
                        end
                        OP_JMP: begin
                            pc <= res[AW-1:0];
                            c  <= cout;
                        end
                        OP_HLT: pc <= pc;
                        default: ;
                    endcase
                    if (opcode == OP_HLT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (run) begin
                        state <= S_FETCH;
                        req_r <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
